// File: rtl/multimode_ff_bank.sv
// multimode_ff_bank: WIDTH-bit flip-flop bank that acts as SR, JK, D or T
// flip-flops under run-time mode control. In SR mode, S=R=1 resolves to a
// fixed parameter-selected value. Such cycles are reported as conflicts:
// a registered one-cycle pulse, a sticky flag and a saturating counter.
module multimode_ff_bank #(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0,
  parameter int               SR_CONFLICT = 0,   // 0 hold, 1 set wins, 2 reset wins
  parameter int               CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q1,
  output logic             err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    MODE_SR = 2'b00,
    MODE_JK = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } mode_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Any SR_CONFLICT value other than 0..2 has no defined meaning.
  if (SR_CONFLICT < 0 || SR_CONFLICT > 2) begin : g_bad_sr_conflict
    $error("multimode_ff_bank: SR_CONFLICT must be 0, 1 or 2");
  end

  logic [WIDTH-1:0] q_q, q_d;
  logic             err_q, err_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             conflict;
  mode_e            mode_s;

  assign mode_s   = mode_e'(mode);
  assign conflict = en && (mode_s == MODE_SR) && ((a & b) != '0);

  // Per-bit next state of the bank for the selected mode.
  always_comb begin
    // NOTE: q_d gets a default first, so every path assigns it and no latch is inferred.
    q_d = q_q;
    if (en) begin
      for (int i = 0; i < WIDTH; i++) begin
        unique case (mode_s)
          MODE_SR: begin
            unique case ({a[i], b[i]})
              2'b00: q_d[i] = q_q[i];
              2'b01: q_d[i] = 1'b0;
              2'b10: q_d[i] = 1'b1;
              2'b11: begin
                if (SR_CONFLICT == 1)      q_d[i] = 1'b1;
                else if (SR_CONFLICT == 2) q_d[i] = 1'b0;
                else                       q_d[i] = q_q[i];
              end
            endcase
          end
          MODE_JK: begin
            unique case ({a[i], b[i]})
              2'b00: q_d[i] = q_q[i];
              2'b01: q_d[i] = 1'b0;
              2'b10: q_d[i] = 1'b1;
              2'b11: q_d[i] = ~q_q[i];
            endcase
          end
          MODE_D: q_d[i] = a[i];
          MODE_T: q_d[i] = a[i] ? ~q_q[i] : q_q[i];
        endcase
      end
    end
  end

  // Conflict bookkeeping: a fresh conflict outranks clr_err at the same edge.
  always_comb begin
    err_d    = conflict;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (conflict) begin
      sticky_d = 1'b1;
      if (clr_err)               cnt_d = CNT_W'(1);
      else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    end else if (clr_err) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
    end
  end

  // State registers; reset clears everything at once, including a pending err pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q      <= RESET_VAL;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      q_q      <= q_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign q          = q_q;
  assign q1         = ~q_q;
  assign err        = err_q;
  assign err_sticky = sticky_q;
  assign err_cnt    = cnt_q;

endmodule

// File: tb/tb_multimode_ff_bank.sv
// Directed bench for multimode_ff_bank. Four instances share one stimulus:
// A (RESET_VAL=1010, hold on S=R=1), B (set wins), C (reset wins), D (CNT_W=2).
module tb_multimode_ff_bank;

  localparam logic [1:0] M_SR = 2'b00, M_JK = 2'b01, M_D = 2'b10, M_T = 2'b11;

  logic       clk, rst, en, clr_err;
  logic [1:0] mode;
  logic [3:0] a, b;

  logic [3:0] qa, q1a, qb, q1b, qc, q1c, qd, q1d;
  logic       erra, stka, errb, stkb, errc, stkc, errd, stkd;
  logic [7:0] cnta, cntb, cntc;
  logic [1:0] cntd;

  int checks = 0;
  int errors = 0;

  multimode_ff_bank #(.WIDTH(4), .RESET_VAL(4'b1010), .SR_CONFLICT(0), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .clr_err(clr_err),
    .q(qa), .q1(q1a), .err(erra), .err_sticky(stka), .err_cnt(cnta));

  multimode_ff_bank #(.WIDTH(4), .RESET_VAL(4'b0000), .SR_CONFLICT(1), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .clr_err(clr_err),
    .q(qb), .q1(q1b), .err(errb), .err_sticky(stkb), .err_cnt(cntb));

  multimode_ff_bank #(.WIDTH(4), .RESET_VAL(4'b0000), .SR_CONFLICT(2), .CNT_W(8)) dut_c (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .clr_err(clr_err),
    .q(qc), .q1(q1c), .err(errc), .err_sticky(stkc), .err_cnt(cntc));

  multimode_ff_bank #(.WIDTH(4), .RESET_VAL(4'b0000), .SR_CONFLICT(0), .CNT_W(2)) dut_d (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .clr_err(clr_err),
    .q(qd), .q1(q1d), .err(errd), .err_sticky(stkd), .err_cnt(cntd));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle 1 time unit before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [1:0] m, input logic [3:0] av,
                       input logic [3:0] bv, input logic c);
    en = e; mode = m; a = av; b = bv; clr_err = c;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, M_SR, 4'b0000, 4'b0000, 1'b0);
    step();
    step();
    check("rst_q",      32'(qa),   32'(4'b1010));
    check("rst_q1",     32'(q1a),  32'(4'b0101));
    check("rst_err",    32'(erra), 0);
    check("rst_sticky", 32'(stka), 0);
    check("rst_cnt",    32'(cnta), 0);

    // First edge after reset release is a normal D load.
    rst = 1'b0;
    drive(1'b1, M_D, 4'b0101, 4'b0000, 1'b0);
    step();
    check("first_edge_q", 32'(qa), 32'(4'b0101));

    // Async reset between edges acts immediately.
    #2 rst = 1'b1;
    #1;
    check("async_rst_q",  32'(qa),  32'(4'b1010));
    check("async_rst_q1", 32'(q1a), 32'(4'b0101));
    rst = 1'b0;

    // Load 0000, then the SR test vector.
    drive(1'b1, M_D, 4'b0000, 4'b0000, 1'b0);
    step();
    check("load0_q", 32'(qa), 0);
    drive(1'b1, M_SR, 4'b0011, 4'b0101, 1'b0);
    step();
    check("sr_hold_q",   32'(qa),   32'(4'b0010));
    check("sr_set_q",    32'(qb),   32'(4'b0011));
    check("sr_reset_q",  32'(qc),   32'(4'b0010));
    check("sr_q1",       32'(q1b),  32'(4'b1100));
    check("sr_err",      32'(erra), 1);
    check("sr_sticky",   32'(stka), 1);
    check("sr_cnt",      32'(cnta), 1);

    // en=0: err drops, sticky/cnt/q hold.
    drive(1'b0, M_SR, 4'b1111, 4'b1111, 1'b0);
    step();
    check("en0_err",    32'(erra), 0);
    check("en0_sticky", 32'(stka), 1);
    check("en0_cnt",    32'(cnta), 1);
    check("en0_q",      32'(qa),   32'(4'b0010));

    // JK toggle: never a conflict.
    drive(1'b1, M_D, 4'b0000, 4'b0000, 1'b0);
    step();
    drive(1'b1, M_JK, 4'b1111, 4'b1111, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("jk_q%0d", i), 32'(qa), (i % 2 == 0) ? 32'hF : 32'h0);
      check($sformatf("jk_err%0d", i), 32'(erra), 0);
    end
    check("jk_cnt", 32'(cnta), 1);

    // T then D then disabled edge.
    drive(1'b1, M_T, 4'b0001, 4'b0000, 1'b0);
    step();
    check("t1_q", 32'(qa), 32'(4'b0001));
    drive(1'b1, M_T, 4'b1111, 4'b0000, 1'b0);
    step();
    check("t2_q", 32'(qa), 32'(4'b1110));
    drive(1'b1, M_D, 4'b0110, 4'b1111, 1'b0);
    step();
    check("d_q", 32'(qa), 32'(4'b0110));
    drive(1'b0, M_D, 4'b1001, 4'b0000, 1'b0);
    step();
    check("en0_d_q",  32'(qa),  32'(4'b0110));
    check("en0_d_q1", 32'(q1a), 32'(4'b1001));

    // clr_err alone on a disabled edge; q untouched.
    drive(1'b0, M_SR, 4'b0000, 4'b0000, 1'b1);
    step();
    check("clr_cnt_d",    32'(cntd), 0);
    check("clr_sticky_d", 32'(stkd), 0);
    check("clr_q_a",      32'(qa),   32'(4'b0110));

    // Saturation with CNT_W=2.
    drive(1'b1, M_SR, 4'b0001, 4'b0001, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("sat_cnt%0d", i), 32'(cntd), (i < 3) ? 32'(i + 1) : 32'd3);
      check($sformatf("sat_err%0d", i), 32'(errd), 1);
    end
    drive(1'b1, M_SR, 4'b0001, 4'b0001, 1'b1);
    step();
    check("clr_conf_cnt",    32'(cntd), 1);
    check("clr_conf_sticky", 32'(stkd), 1);
    check("clr_conf_err",    32'(errd), 1);
    drive(1'b0, M_SR, 4'b0000, 4'b0000, 1'b1);
    step();
    check("clr_only_cnt",    32'(cntd), 0);
    check("clr_only_sticky", 32'(stkd), 0);
    check("clr_only_err",    32'(errd), 0);

    // Reset one cycle after a conflict kills the err pulse.
    drive(1'b1, M_SR, 4'b1000, 4'b1000, 1'b0);
    step();
    check("pre_rst_err", 32'(erra), 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_err", 32'(erra), 0);
    check("mid_rst_q",   32'(qa),   32'(4'b1010));
    check("mid_rst_cnt", 32'(cnta), 0);
    drive(1'b0, M_SR, 4'b0000, 4'b0000, 1'b0);
    rst = 1'b0;
    step();
    check("post_rst_err", 32'(erra), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
